// File: rtl/click_token_injector.sv
// Clocked token source for the asynchronous click pipeline: issues two-phase
// request tokens, tracks ack/retire through synchronisers, flags stalls.

module click_tok_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

module click_token_injector #(
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_tokens,
  input  logic             i_abort,
  output logic             o_reqL,
  input  logic             i_ackL,
  input  logic             i_reqR,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_issued,
  output logic [CNT_W-1:0] o_retired
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             reqL_q, reqL_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             req_prev_q;

  logic             ack_s, req_s, retire_ev, tmr_count;
  logic [CNT_W-1:0] in_flight;
  logic [TMR_W-1:0] timer_inc;

  click_tok_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .i_clk(i_clk), .i_rst(i_rst), .d_i(i_ackL), .q_o(ack_s)
  );
  click_tok_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk(i_clk), .i_rst(i_rst), .d_i(i_reqR), .q_o(req_s)
  );

  assign retire_ev = req_s ^ req_prev_q;
  assign in_flight = issued_q - retired_q;
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    timer_d   = timer_q;
    reqL_d    = reqL_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    tmr_count = 1'b0;

    // Retirements are tracked in every state; stray toggles beyond issued are dropped
    if (retire_ev && (retired_q < issued_q)) retired_d = retired_q + 1'b1;

    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            if (i_num_tokens != '0) begin
              target_d  = i_num_tokens;
              issued_d  = '0;
              retired_d = '0;
              timer_d   = '0;
              timeout_d = 1'b0;
              state_d   = ISSUE;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (in_flight < CNT_W'(MAX_INFLIGHT)) begin
            reqL_d   = ~reqL_q;
            issued_d = issued_q + 1'b1;
            timer_d  = '0;
            state_d  = WAIT_ACK;
          end else begin
            tmr_count = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_s == reqL_q) begin
            timer_d = '0;
            state_d = (issued_q == target_q) ? DRAIN : ISSUE;
          end else begin
            tmr_count = 1'b1;
          end
        end
        DRAIN: begin
          if (retired_q == target_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (retire_ev) begin
            timer_d = '0;
          end else begin
            tmr_count = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (tmr_count) begin
        timer_d = timer_inc;
        if (timer_inc == TMR_W'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      timer_q    <= '0;
      reqL_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      timer_q    <= timer_d;
      reqL_q     <= reqL_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      req_prev_q <= req_s;
    end
  end

  assign o_reqL    = reqL_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_issued  = issued_q;
  assign o_retired = retired_q;
endmodule
